// File: rtl/post_sub_divider_asyncrst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : post_sub_divider_asyncrst_pkg
// Description : Shared constants for the iterative restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package post_sub_divider_asyncrst_pkg;

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_LOAD  = 3'd1;
  localparam logic [2:0] c_ST_ITER  = 3'd2;
  localparam logic [2:0] c_ST_FIXUP = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_LOAD  = c_ST_LOAD,
    ST_ITER  = c_ST_ITER,
    ST_FIXUP = c_ST_FIXUP,
    ST_DONE  = c_ST_DONE
  } state_t;

  localparam string c_MODE_UNSIGNED = "UNSIGNED";
  localparam string c_MODE_SIGNED   = "SIGNED";

  localparam int c_DEFAULT_N = 36;
  localparam int c_DEFAULT_M = 18;

  // Iteration counter width: counts 0 .. N-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/post_sub_divider_asyncrst_if.sv
`default_nettype none
// ============================================================================
// Module      : post_sub_divider_asyncrst_if
// Description : Start/done handshake and operand/result bundle of the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface post_sub_divider_asyncrst_if
  import post_sub_divider_asyncrst_pkg::*;
#(
  parameter int DIVIDEND_width = c_DEFAULT_N,
  parameter int DIVISOR_width  = c_DEFAULT_M
);

  logic                      start;
  logic [DIVIDEND_width-1:0] dividend;
  logic [DIVISOR_width-1:0]  divisor;
  logic                      ready;
  logic                      busy;
  logic                      done;
  logic [DIVIDEND_width-1:0] quotient;
  logic [DIVISOR_width-1:0]  remainder;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output start, dividend, divisor,
    input  ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, busy, done, quotient, remainder, div_by_zero, overflow
  );

endinterface
`default_nettype wire

// File: rtl/post_sub_divider_asyncrst_div_trial_sub.sv
`default_nettype none
// ============================================================================
// Module      : div_trial_sub
// Description : Combinational trial subtractor for one restoring-division step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_trial_sub #(
  parameter int WIDTH = 19
) (
  input  logic [WIDTH-1:0] i_rem_shifted,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-2:0] o_difference,
  output logic             o_borrow
);

  logic [WIDTH-1:0] w_full;

  // The top bit of the WIDTH-bit difference flags a failed trial; the lower
  // bits are the new partial remainder when the trial succeeds.
  assign w_full       = i_rem_shifted - i_divisor;
  assign o_difference = w_full[WIDTH-2:0];
  assign o_borrow     = w_full[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/post_sub_divider_asyncrst.sv
`default_nettype none
// ============================================================================
// Module      : post_sub_divider_asyncrst
// Description : Iterative restoring divider, one quotient bit per enabled clock.
// Revision    : 1.0 - initial release
// ============================================================================
module post_sub_divider_asyncrst
  import post_sub_divider_asyncrst_pkg::*;
#(
  parameter int    DIVIDEND_width = c_DEFAULT_N,
  parameter int    DIVISOR_width  = c_DEFAULT_M,
  parameter string DIV_MODE       = c_MODE_UNSIGNED
) (
  input  logic CLK,
  input  logic rst_a,
  input  logic C_ENABLE,
  post_sub_divider_asyncrst_if.slave bus
);

  localparam int c_N     = DIVIDEND_width;
  localparam int c_M     = DIVISOR_width;
  localparam int c_CNT_W = cnt_width(c_N);

  localparam logic [c_N-1:0]     c_MOST_NEG = {1'b1, {(c_N-1){1'b0}}};
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CNT_W-1:0] r_cnt;
  logic [c_N-1:0]     r_dividend;
  logic [c_M-1:0]     r_divisor;
  logic [c_M-1:0]     r_rem;
  logic [c_N-1:0]     r_q;
  logic [c_M-1:0]     r_dv_mag;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_ovf_pend;

  logic [c_N-1:0]     r_quotient;
  logic [c_M-1:0]     r_remainder;
  logic               r_div_by_zero;
  logic               r_overflow;

  logic               w_dd_neg;
  logic               w_dv_neg;
  logic [c_N-1:0]     w_dd_mag;
  logic [c_M-1:0]     w_dv_mag;
  logic               w_div_zero;
  logic               w_ovf;
  logic               w_last;
  logic [c_M:0]       w_rem_sh;
  logic [c_M-1:0]     w_diff;
  logic               w_borrow;
  logic [c_N-1:0]     w_q_final;
  logic [c_M-1:0]     w_r_final;

  // ---------------------------------------------------------------------
  // Operand sign handling
  // ---------------------------------------------------------------------
  generate
    if (DIV_MODE == c_MODE_SIGNED) begin : g_signed
      assign w_dd_neg = r_dividend[c_N-1];
      assign w_dv_neg = r_divisor[c_M-1];
    end else begin : g_unsigned
      assign w_dd_neg = 1'b0;
      assign w_dv_neg = 1'b0;
    end
  endgenerate

  // The most-negative magnitudes still fit as unsigned values of the same width.
  assign w_dd_mag   = w_dd_neg ? -r_dividend : r_dividend;
  assign w_dv_mag   = w_dv_neg ? -r_divisor  : r_divisor;
  assign w_div_zero = (r_divisor == '0);
  assign w_ovf      = w_dd_neg && w_dv_neg && (r_dividend == c_MOST_NEG) && (&r_divisor);
  assign w_last     = (r_cnt == c_CNT_LAST);

  // ---------------------------------------------------------------------
  // Shift-and-trial-subtract step
  // ---------------------------------------------------------------------
  assign w_rem_sh = {r_rem, r_q[c_N-1]};

  div_trial_sub #(
    .WIDTH (c_M + 1)
  ) u_trial_sub (
    .i_rem_shifted (w_rem_sh),
    .i_divisor     ({1'b0, r_dv_mag}),
    .o_difference  (w_diff),
    .o_borrow      (w_borrow)
  );

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_q_final = r_q_neg ? -r_q   : r_q;
  assign w_r_final = r_r_neg ? -r_rem : r_rem;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_a) begin
    if (!rst_a) begin
      r_state <= ST_IDLE;
    end else if (C_ENABLE) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_LOAD;
      ST_LOAD:  w_state_nxt = w_div_zero ? ST_DONE : ST_ITER;
      ST_ITER:  if (w_last) w_state_nxt = ST_FIXUP;
      ST_FIXUP: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_a) begin
    if (!rst_a) begin
      r_cnt         <= '0;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_rem         <= '0;
      r_q           <= '0;
      r_dv_mag      <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_ovf_pend    <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (C_ENABLE) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_dividend <= bus.dividend;
            r_divisor  <= bus.divisor;
          end
        end
        ST_LOAD: begin
          r_cnt      <= '0;
          r_rem      <= '0;
          r_q        <= w_dd_mag;
          r_dv_mag   <= w_dv_mag;
          r_q_neg    <= w_dd_neg ^ w_dv_neg;
          r_r_neg    <= w_dd_neg;
          r_ovf_pend <= w_ovf;
          if (w_div_zero) begin
            r_quotient    <= '1;
            r_remainder   <= r_dividend[c_M-1:0];
            r_div_by_zero <= 1'b1;
            r_overflow    <= 1'b0;
          end
        end
        ST_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          // The partial remainder always stays below the divisor, so M bits hold it.
          r_rem <= w_borrow ? w_rem_sh[c_M-1:0] : w_diff;
          r_q   <= {r_q[c_N-2:0], ~w_borrow};
        end
        ST_FIXUP: begin
          r_quotient    <= w_q_final;
          r_remainder   <= w_r_final;
          r_div_by_zero <= 1'b0;
          r_overflow    <= r_ovf_pend;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ready       = (r_state == ST_IDLE);
  assign bus.busy        = (r_state == ST_LOAD) || (r_state == ST_ITER) || (r_state == ST_FIXUP);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;
  assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_post_sub_divider_asyncrst.sv
`default_nettype none
// ============================================================================
// Module      : tb_post_sub_divider_asyncrst
// Description : Self-checking bench for the divider, unsigned and signed builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_post_sub_divider_asyncrst;
  import post_sub_divider_asyncrst_pkg::*;

  localparam int c_N    = 36;
  localparam int c_M    = 18;
  localparam int c_NVEC = 11;
  localparam int c_LAT  = c_N + 2;

  typedef struct {
    bit          sgn;
    logic [35:0] a;
    logic [17:0] b;
    logic [35:0] q;
    logic [17:0] r;
    bit          dz;
    bit          ov;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic cen;
  logic sel;
  logic tb_start;
  logic [35:0] tb_a;
  logic [17:0] tb_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  post_sub_divider_asyncrst_if #(.DIVIDEND_width(c_N), .DIVISOR_width(c_M)) bus_u ();
  post_sub_divider_asyncrst_if #(.DIVIDEND_width(c_N), .DIVISOR_width(c_M)) bus_s ();

  post_sub_divider_asyncrst #(
    .DIVIDEND_width (c_N),
    .DIVISOR_width  (c_M),
    .DIV_MODE       (c_MODE_UNSIGNED)
  ) u_dut_u (
    .CLK      (clk),
    .rst_a    (rst_a),
    .C_ENABLE (cen),
    .bus      (bus_u)
  );

  post_sub_divider_asyncrst #(
    .DIVIDEND_width (c_N),
    .DIVISOR_width  (c_M),
    .DIV_MODE       (c_MODE_SIGNED)
  ) u_dut_s (
    .CLK      (clk),
    .rst_a    (rst_a),
    .C_ENABLE (cen),
    .bus      (bus_s)
  );

  // Shared operands; only the selected instance sees start.
  assign bus_u.start    = tb_start & ~sel;
  assign bus_s.start    = tb_start & sel;
  assign bus_u.dividend = tb_a;
  assign bus_s.dividend = tb_a;
  assign bus_u.divisor  = tb_b;
  assign bus_s.divisor  = tb_b;

  logic        m_ready, m_busy, m_done, m_dz, m_ov;
  logic [35:0] m_q;
  logic [17:0] m_r;
  assign m_ready = sel ? bus_s.ready       : bus_u.ready;
  assign m_busy  = sel ? bus_s.busy        : bus_u.busy;
  assign m_done  = sel ? bus_s.done        : bus_u.done;
  assign m_dz    = sel ? bus_s.div_by_zero : bus_u.div_by_zero;
  assign m_ov    = sel ? bus_s.overflow    : bus_u.overflow;
  assign m_q     = sel ? bus_s.quotient    : bus_u.quotient;
  assign m_r     = sel ? bus_s.remainder   : bus_u.remainder;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".ready"},     m_ready, 1);
    check({tag, ".busy"},      m_busy,  0);
    check({tag, ".done"},      m_done,  0);
    check({tag, ".quotient"},  m_q,     0);
    check({tag, ".remainder"}, m_r,     0);
    check({tag, ".dz"},        m_dz,    0);
    check({tag, ".ov"},        m_ov,    0);
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void ref_div(input bit sgn, input logic [35:0] a, input logic [17:0] b,
                                  output logic [35:0] q, output logic [17:0] r,
                                  output bit dz, output bit ov);
    longint sa, sb, lq, lr;
    if (b == 18'd0) begin
      q = '1; r = a[17:0]; dz = 1'b1; ov = 1'b0;
      return;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[35:0];
    r  = lr[17:0];
    dz = 1'b0;
    ov = sgn && (a == 36'h8_0000_0000) && (b == 18'h3FFFF);
  endfunction

  function automatic bit invariant_ok(input bit sgn, input logic [35:0] a, input logic [17:0] b,
                                      input logic [35:0] q, input logic [17:0] r);
    longint sa, sb, sq, sr, abs_r, abs_b;
    if (sgn) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      sq = longint'($signed(q)); sr = longint'($signed(r));
    end else begin
      sa = longint'(a); sb = longint'(b);
      sq = longint'(q); sr = longint'(r);
    end
    abs_r = (sr < 0) ? -sr : sr;
    abs_b = (sb < 0) ? -sb : sb;
    return (sa == sq * sb + sr) && (abs_r < abs_b);
  endfunction

  task automatic wait_ready();
    @(negedge clk);
    for (int g = 0; g < 50 && !m_ready; g++) @(negedge clk);
  endtask

  // Issues one operation; lat counts enabled-or-not edges after the accepting edge.
  task automatic run_op(input bit sgn, input logic [35:0] a, input logic [17:0] b,
                        input int stall_at, input int stall_len,
                        output int lat, output bit hs_ok);
    sel = sgn;
    wait_ready();
    tb_a = a; tb_b = b; tb_start = 1'b1;
    @(posedge clk); #1;
    tb_start = 1'b0;
    lat = 0; hs_ok = 1'b1;
    while (lat < 300) begin
      @(posedge clk); lat++; #1;
      if (m_done) break;
      if (m_ready || !m_busy) hs_ok = 1'b0;
      if (stall_at != 0 && lat == stall_at) cen = 1'b0;
      if (stall_at != 0 && lat == stall_at + stall_len) cen = 1'b1;
    end
  endtask

  vec_t        vecs [c_NVEC];
  int          lat;
  bit          hs_ok;
  logic [35:0] eq;
  logic [17:0] er;
  bit          edz, eov;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 36'd100,          18'd7,       36'd14,           18'd2,       1'b0, 1'b0};
    vecs[1]  = '{1'b0, 36'd55,           18'd0,       36'hF_FFFF_FFFF,  18'd55,      1'b1, 1'b0};
    vecs[2]  = '{1'b1, 36'hF_FFFF_FF9C,  18'd7,       36'hF_FFFF_FFF2,  18'h3FFFE,   1'b0, 1'b0};
    vecs[3]  = '{1'b1, 36'd100,          18'h3FFF9,   36'hF_FFFF_FFF2,  18'd2,       1'b0, 1'b0};
    vecs[4]  = '{1'b1, 36'h8_0000_0000,  18'h3FFFF,   36'h8_0000_0000,  18'd0,       1'b0, 1'b1};
    vecs[5]  = '{1'b0, 36'hF_FFFF_FFFF,  18'd1,       36'hF_FFFF_FFFF,  18'd0,       1'b0, 1'b0};
    vecs[6]  = '{1'b0, 36'd5,            18'd9,       36'd0,            18'd5,       1'b0, 1'b0};
    vecs[7]  = '{1'b1, 36'hF_FFFF_FFF9,  18'h3FFF9,   36'd1,            18'd0,       1'b0, 1'b0};
    vecs[8]  = '{1'b0, 36'hF_FFFF_FFFF,  18'h3FFFF,   36'h4_0001,       18'd0,       1'b0, 1'b0};
    vecs[9]  = '{1'b1, 36'd0,            18'h3FFFB,   36'd0,            18'd0,       1'b0, 1'b0};
    vecs[10] = '{1'b1, 36'hF_FFFF_FFFF,  18'd0,       36'hF_FFFF_FFFF,  18'h3FFFF,   1'b1, 1'b0};

    rst_a = 1'b0; cen = 1'b1; sel = 1'b0; tb_start = 1'b0; tb_a = '0; tb_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset_u");
    sel = 1'b1; #1;
    check_idle_zero("reset_s");
    @(negedge clk); rst_a = 1'b1;

    // Directed vector table
    for (int i = 0; i < c_NVEC; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, 0, lat, hs_ok);
      check($sformatf("vec%0d.latency", i),   lat,    vecs[i].dz ? 1 : c_LAT);
      check($sformatf("vec%0d.handshake", i), hs_ok,  1);
      check($sformatf("vec%0d.quotient", i),  m_q,    vecs[i].q);
      check($sformatf("vec%0d.remainder", i), m_r,    vecs[i].r);
      check($sformatf("vec%0d.dz", i),        m_dz,   vecs[i].dz);
      check($sformatf("vec%0d.ov", i),        m_ov,   vecs[i].ov);
    end

    // Clock-enable stall in ITER, then hold in DONE
    run_op(1'b0, 36'd100, 18'd7, 15, 5, lat, hs_ok);
    check("stall.latency",   lat, c_LAT + 5);
    check("stall.quotient",  m_q, 14);
    check("stall.remainder", m_r, 2);
    cen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall.done_hold", m_done, 1);
    cen = 1'b1;
    @(posedge clk); #1;
    check("stall.done_end",   m_done,  0);
    check("stall.ready_back", m_ready, 1);

    // Asynchronous reset during ITER
    sel = 1'b0;
    wait_ready();
    tb_a = 36'd1000; tb_b = 18'd3; tb_start = 1'b1;
    @(posedge clk); #1;
    tb_start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_a = 1'b0;
    #1;
    check_idle_zero("midreset");
    @(negedge clk); rst_a = 1'b1;
    run_op(1'b0, 36'd1000, 18'd3, 0, 0, lat, hs_ok);
    check("after_reset.latency",   lat, c_LAT);
    check("after_reset.quotient",  m_q, 333);
    check("after_reset.remainder", m_r, 1);

    // Start held high: next op accepted on the first IDLE edge after DONE
    sel = 1'b0;
    wait_ready();
    tb_a = 36'd100; tb_b = 18'd7; tb_start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); lat++; #1;
      if (m_done) break;
    end
    check("b2b.first_latency", lat, c_LAT);
    tb_a = 36'd1000; tb_b = 18'd3;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); lat++; #1;
      if (m_done) break;
    end
    check("b2b.second_latency",   lat, c_LAT + 2);
    check("b2b.second_quotient",  m_q, 333);
    check("b2b.second_remainder", m_r, 1);
    tb_start = 1'b0;

    // Start pulses while busy are ignored and not queued
    sel = 1'b1;
    wait_ready();
    tb_a = 36'hF_FFFF_FF9C; tb_b = 18'd7; tb_start = 1'b1;
    @(posedge clk); #1;
    tb_start = 1'b0;
    lat = 0;
    while (lat < 300) begin
      @(posedge clk); lat++; #1;
      if (m_done) break;
      if (lat == 10) begin tb_start = 1'b1; tb_a = 36'd55; tb_b = 18'd0; end
      if (lat == 12) tb_start = 1'b0;
    end
    check("ignore.latency",   lat, c_LAT);
    check("ignore.quotient",  m_q, 36'hF_FFFF_FFF2);
    check("ignore.remainder", m_r, 18'h3FFFE);
    check("ignore.dz",        m_dz, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ignore.no_queue", m_ready, 1);

    // Randomized regression against the reference model
    for (int k = 0; k < 40; k++) begin
      logic [63:0] ra;
      logic [35:0] a;
      logic [17:0] b;
      bit          sgn;
      ra = {$urandom(), $urandom()};
      a  = ra[35:0];
      if ($urandom_range(0, 3) == 0) a = 36'($urandom_range(0, 2000));
      case ($urandom_range(0, 7))
        0:       b = 18'd0;
        1, 2:    b = 18'($urandom_range(1, 20));
        default: b = 18'($urandom());
      endcase
      sgn = k[0];
      if (sgn && $urandom_range(0, 9) == 0) begin
        a = 36'h8_0000_0000; b = 18'h3FFFF;
      end
      ref_div(sgn, a, b, eq, er, edz, eov);
      run_op(sgn, a, b, 0, 0, lat, hs_ok);
      check($sformatf("rand%0d.latency", k),   lat, edz ? 1 : c_LAT);
      check($sformatf("rand%0d.quotient", k),  m_q, eq);
      check($sformatf("rand%0d.remainder", k), m_r, er);
      check($sformatf("rand%0d.dz", k),        m_dz, edz);
      check($sformatf("rand%0d.ov", k),        m_ov, eov);
      if (!edz && !eov)
        check($sformatf("rand%0d.invariant", k), invariant_ok(sgn, a, b, m_q, m_r), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
